// File: rtl/motor_pkg.sv
// Shared motor types: direction/torque encodings and executor state.
// Also used by the direction/torque display decoders.
package motor_pkg;

    typedef enum logic [1:0] {
        DIR_FWD   = 2'b00,
        DIR_REV   = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef logic [1:0] torque_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2
    } exec_state_t;

    typedef struct packed {
        torque_t torque;
        dir_t    dir;
    } instr_t;

    // Returns {left_dir, right_dir}; 1 = wheel turns forward.
    function automatic logic [1:0] dir_decode(input dir_t d);
        dir_decode = 2'b00;
        case (d)
            DIR_FWD:   dir_decode = 2'b11;
            DIR_REV:   dir_decode = 2'b00;
            DIR_LEFT:  dir_decode = 2'b01;
            DIR_RIGHT: dir_decode = 2'b10;
            default:   dir_decode = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/motor_executor_pwm_gen.sv
// Free-running PWM with a registered output, computed from the next-cycle
// counter value so the output lines up with the cycle `enable` refers to.
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [PWM_BITS:0] duty,
    output logic              pwm
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + PWM_BITS'(1);
        end
        pwm_d = enable && ({1'b0, cnt_d} < duty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/motor_executor.sv
// Consumes one {torque, dir} instruction per handshake, drives both wheels
// for a fixed run time, brakes for a dead time, then pulses done.
module motor_executor
    import motor_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int RUN_CYCLES  = 50_000_000,
    parameter int DEAD_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_instr,
    output logic       in_ready,
    input  logic       abort,
    output logic       left_pwm,
    output logic       left_dir,
    output logic       right_pwm,
    output logic       right_dir,
    output logic       busy,
    output logic       done
);

    localparam int RUN_W  = (RUN_CYCLES  > 1) ? $clog2(RUN_CYCLES)  : 1;
    localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYCLES - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

    exec_state_t       state_q, state_d;
    logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    instr_t            instr_q, instr_d;
    logic [1:0]        dirs_q, dirs_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              accept;
    logic [PWM_BITS:0] duty;
    logic              pwm;

    assign in_ready = (state_q == IDLE) && !abort && !rst;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        dead_cnt_d = dead_cnt_q;
        instr_d    = instr_q;
        dirs_d     = dirs_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                    instr_d   = instr_t'(in_instr);
                    dirs_d    = dir_decode(dir_t'(in_instr[1:0]));
                end
            end
            RUN: begin
                if (abort || run_cnt_q == RUN_LAST) begin
                    state_d    = BRAKE;
                    dead_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q + RUN_W'(1);
                end
            end
            BRAKE: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Duty uses the torque that will be in force next cycle so the first
    // RUN cycle already sees the newly accepted value.
    assign duty = ({{(PWM_BITS-1){1'b0}}, instr_d.torque} + (PWM_BITS+1)'(1)) << (PWM_BITS-2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            run_cnt_q  <= '0;
            dead_cnt_q <= '0;
            instr_q    <= '0;
            dirs_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            instr_q    <= instr_d;
            dirs_q     <= dirs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) u_pwm_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .enable(state_d == RUN),
        .duty  (duty),
        .pwm   (pwm)
    );

    assign left_pwm  = pwm;
    assign right_pwm = pwm;
    assign left_dir  = dirs_q[1];
    assign right_dir = dirs_q[0];
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_motor_executor.sv
// Bench for motor_executor: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_motor_executor;

    localparam int PWM_BITS    = 4;
    localparam int RUN_CYCLES  = 20;
    localparam int DEAD_CYCLES = 4;
    localparam int PERIOD      = 2 ** PWM_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_instr = 4'b0000;
    logic       abort = 1'b0;
    logic       in_ready, left_pwm, left_dir, right_pwm, right_dir, busy, done;

    int tests = 0;
    int fails = 0;

    motor_executor #(
        .PWM_BITS   (PWM_BITS),
        .RUN_CYCLES (RUN_CYCLES),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .abort    (abort),
        .left_pwm (left_pwm),
        .left_dir (left_dir),
        .right_pwm(right_pwm),
        .right_dir(right_dir),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an instruction is a timeline measured in cycles since
    // its acceptance edge (age). Drive for run_len cycles, then DEAD_CYCLES of
    // brake, then one retirement cycle with done.
    bit m_act  = 1'b0;
    bit m_done = 1'b0;
    bit m_ldir = 1'b0;
    bit m_rdir = 1'b0;
    int m_age = 0;
    int m_run_len = 0;
    int m_torque = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_act  = 1'b0;
            m_done = 1'b0;
            m_ldir = 1'b0;
            m_rdir = 1'b0;
            m_age  = 0;
        end else begin
            m_done = 1'b0;
            if (m_act) begin
                if (m_age < m_run_len && abort) m_run_len = m_age + 1;
                m_age++;
                if (m_age == m_run_len + DEAD_CYCLES) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end else if (in_valid && !abort) begin
                m_act     = 1'b1;
                m_age     = 0;
                m_run_len = RUN_CYCLES;
                m_torque  = int'(in_instr[3:2]);
                case (in_instr[1:0])
                    2'b00:   begin m_ldir = 1'b1; m_rdir = 1'b1; end
                    2'b01:   begin m_ldir = 1'b0; m_rdir = 1'b0; end
                    2'b10:   begin m_ldir = 1'b0; m_rdir = 1'b1; end
                    default: begin m_ldir = 1'b1; m_rdir = 1'b0; end
                endcase
            end
        end
    end

    function automatic int exp_pwm();
        if (rst || !m_act || m_age >= m_run_len) return 0;
        return ((m_age % PERIOD) < (m_torque + 1) * PERIOD / 4) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        chk("in_ready",  int'(in_ready),  int'(!rst && !m_act && !abort));
        chk("busy",      int'(busy),      int'(!rst && m_act));
        chk("done",      int'(done),      int'(!rst && m_done));
        chk("left_pwm",  int'(left_pwm),  exp_pwm());
        chk("right_pwm", int'(right_pwm), exp_pwm());
        chk("left_dir",  int'(left_dir),  int'(!rst && m_ldir));
        chk("right_dir", int'(right_dir), int'(!rst && m_rdir));
    end

    task automatic do_accept(input logic [3:0] ins);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_instr = ins;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int seen = 0;
        for (int c = 0; c < 60 && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk(nm, seen, 1);
    endtask

    initial begin
        int busy_n, pwm_n, pwm_b, done_at;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk("t1_ready_in_rst", int'(in_ready), 0);
        chk("t1_busy_rst", int'(busy), 0);
        chk("t1_dir_rst", int'(left_dir | right_dir), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t1_ready_after_rst", int'(in_ready), 1);
        repeat (5) @(negedge clk);
        chk("t1_no_done", int'(done), 0);

        // 2: torque 1, forward
        do_accept(4'b01_00);
        busy_n = 0; pwm_n = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (c < 16 && left_pwm) pwm_n++;
            if (done && done_at < 0) done_at = c;
        end
        chk("t2_busy_cycles", busy_n, 24);
        chk("t2_pwm_high_of_16", pwm_n, 8);
        chk("t2_done_cycle", done_at, 24);
        chk("t2_left_dir", int'(left_dir), 1);
        chk("t2_right_dir", int'(right_dir), 1);

        // 3: torque 3, left turn
        do_accept(4'b11_10);
        pwm_n = 0; pwm_b = 0; done_at = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c < 20 && right_pwm) pwm_n++;
            if (c >= 20 && c < 24 && right_pwm) pwm_b++;
            if (done && done_at < 0) done_at = c;
        end
        chk("t3_pwm_run_high", pwm_n, 20);
        chk("t3_pwm_brake_high", pwm_b, 0);
        chk("t3_done_cycle", done_at, 24);
        chk("t3_left_dir", int'(left_dir), 0);
        chk("t3_right_dir", int'(right_dir), 1);

        // 4: abort at RUN cycle 5, back-to-back accept on the done cycle
        do_accept(4'b01_11);
        pwm_n = 0; pwm_b = 0; done_at = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c < 6 && left_pwm) pwm_n++;
            if (c >= 6 && left_pwm) pwm_b++;
            if (done) begin
                done_at = c;
                break;
            end
            if (c == 5) begin #1; abort = 1'b1; end
            if (c == 6) begin #1; abort = 1'b0; end
        end
        chk("t4_pwm_before_abort", pwm_n, 6);
        chk("t4_pwm_after_abort", pwm_b, 0);
        chk("t4_done_cycle", done_at, 10);
        chk("t4_ready_on_done", int'(in_ready), 1);
        #1;
        in_valid = 1'b1;
        in_instr = 4'b00_00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t4_b2b_busy", int'(busy), 1);
        wait_done("t4_b2b_done_timeout");

        // 5: abort beats in_valid in IDLE
        @(posedge clk); #1;
        in_valid = 1'b1;
        abort    = 1'b1;
        in_instr = 4'b10_01;
        @(negedge clk);
        chk("t5_ready_abort", int'(in_ready), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t5_not_accepted", int'(busy), 0);
        chk("t5_ready_again", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_accepted", int'(busy), 1);
        chk("t5_rev_left_dir", int'(left_dir), 0);
        wait_done("t5_done_timeout");

        // 6: in_instr change mid-RUN, reset mid-BRAKE
        do_accept(4'b01_00);
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (c == 3) begin #1; in_instr = 4'b10_11; end
            if (c == 10) begin
                chk("t6_dir_held_l", int'(left_dir), 1);
                chk("t6_dir_held_r", int'(right_dir), 1);
            end
            if (c == 21) begin
                chk("t6_busy_in_brake", int'(busy), 1);
                #1;
                rst = 1'b1;
                #1;
                chk("t6_rst_busy", int'(busy), 0);
                chk("t6_rst_dir", int'(left_dir | right_dir), 0);
                chk("t6_rst_pwm", int'(left_pwm | right_pwm), 0);
                chk("t6_rst_ready", int'(in_ready), 0);
            end
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            in_valid = ($urandom_range(0, 1) == 1);
            in_instr = 4'($urandom);
            abort    = ($urandom_range(0, 24) == 0);
            rst      = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        rst      = 1'b0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
